// File: rtl/game_round_fsm.sv
// Round/lives controller for one sprite control instance.
// Sequences a round start (position load, then velocity load), gates sprite
// movement during play, and freezes the sprite for a fixed hold after each
// miss. It also keeps the score and remaining lives for the renderer.
// state_dbg exposes the FSM encoding:
//   IDLE=0, LOAD_XY=1, LOAD_DXY=2, PLAY=3, HOLD=4, OVER=5.
module game_round_fsm #(
  parameter int screen_width  = 640,
  parameter int screen_height = 480,
  parameter int w_x           = $clog2(screen_width),
  parameter int w_y           = $clog2(screen_height),
  parameter int DX_WIDTH      = 2,
  parameter int DY_WIDTH      = 2,
  parameter int START_X       = 316,
  parameter int START_Y       = 0,
  parameter int START_DX      = 1,
  parameter int START_DY      = 1,
  parameter int LIVES         = 3,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int SCORE_WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       key_start,
  input  logic                       hit_wall,
  input  logic                       collide,
  output logic                       enable,
  output logic                       sprite_enable_update,
  output logic                       sprite_write_xy,
  output logic                       sprite_write_dxy,
  output logic [w_x-1:0]             sprite_write_x,
  output logic [w_y-1:0]             sprite_write_y,
  output logic signed [DX_WIDTH-1:0] sprite_write_dx,
  output logic signed [DY_WIDTH-1:0] sprite_write_dy,
  output logic [2:0]                 lives,
  output logic [SCORE_WIDTH-1:0]     score,
  output logic                       game_over,
  output logic [2:0]                 state_dbg
);

  // A counter width of at least one bit keeps HOLD_CYCLES=1 legal.
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [2:0]        LIVES_INIT = 3'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_XY  = 3'd1,
    S_LOAD_DXY = 3'd2,
    S_PLAY     = 3'd3,
    S_HOLD     = 3'd4,
    S_OVER     = 3'd5
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              key_prev;
  logic              hit_prev;
  logic              col_prev;
  logic              key_rise;
  logic              hit_rise;
  logic              col_rise;
  logic [HOLD_W-1:0] hold_cnt;

  // Reload values are fixed; the sprite block only samples them on strobes.
  assign sprite_write_x  = w_x'(START_X);
  assign sprite_write_y  = w_y'(START_Y);
  assign sprite_write_dx = DX_WIDTH'(START_DX);
  assign sprite_write_dy = DY_WIDTH'(START_DY);
  assign state_dbg       = state_q;

  assign key_rise = key_start & ~key_prev;
  assign hit_rise = hit_wall  & ~hit_prev;
  assign col_rise = collide   & ~col_prev;

  // Edge-detect history, refreshed every cycle regardless of state so that
  // edges seen in ignoring states are dropped rather than queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_prev <= 1'b0;
      hit_prev <= 1'b0;
      col_prev <= 1'b0;
    end else begin
      key_prev <= key_start;
      hit_prev <= hit_wall;
      col_prev <= collide;
    end
  end

  // Next-state decode; any encoding outside the enum falls back to IDLE.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:     state_d = key_rise ? S_LOAD_XY : S_IDLE;
      S_LOAD_XY:  state_d = S_LOAD_DXY;
      S_LOAD_DXY: state_d = S_PLAY;
      S_PLAY:     state_d = hit_rise ? S_HOLD : S_PLAY;
      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) state_d = (lives != 3'd0) ? S_LOAD_XY : S_OVER;
        else                       state_d = S_HOLD;
      end
      S_OVER:     state_d = key_rise ? S_LOAD_XY : S_OVER;
      default:    state_d = S_IDLE;
    endcase
  end

  // State register with outputs registered from the next state, so each
  // output equals a Moore decode of the current state without glitches.
  // enable stays high in LOAD_DXY because the sprite block's !enable path
  // would otherwise override the velocity write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q              <= S_IDLE;
      enable               <= 1'b0;
      sprite_enable_update <= 1'b0;
      sprite_write_xy      <= 1'b0;
      sprite_write_dxy     <= 1'b0;
      game_over            <= 1'b0;
    end else begin
      state_q              <= state_d;
      enable               <= (state_d == S_LOAD_DXY) || (state_d == S_PLAY);
      sprite_enable_update <= (state_d == S_PLAY);
      sprite_write_xy      <= (state_d == S_LOAD_XY);
      sprite_write_dxy     <= (state_d == S_LOAD_DXY);
      game_over            <= (state_d == S_OVER);
    end
  end

  // Lives, score and hold counter. A miss takes priority over a catch in the
  // same cycle, and lives only drop in PLAY so they cannot wrap below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      lives    <= LIVES_INIT;
      score    <= '0;
      hold_cnt <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_OVER: begin
          if (key_rise) begin
            lives <= LIVES_INIT;
            score <= '0;
          end
        end
        S_PLAY: begin
          if (hit_rise) begin
            lives    <= lives - 3'd1;
            hold_cnt <= '0;
          end else if (col_rise && (score != '1)) begin
            score <= score + 1'b1;
          end
        end
        S_HOLD: hold_cnt <= hold_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_fsm.sv
// Directed bench for game_round_fsm with a short hold time. A second
// instance with a 3-bit score shares the stimulus to exercise saturation.
module tb_game_round_fsm;

  localparam int HOLD = 4;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PLAY = 3'd3;
  localparam logic [2:0] ST_HOLD = 3'd4;
  localparam logic [2:0] ST_OVER = 3'd5;

  logic       clk;
  logic       rst;
  logic       key_start;
  logic       hit_wall;
  logic       collide;

  logic       enable, sprite_enable_update, sprite_write_xy, sprite_write_dxy;
  logic [9:0] sprite_write_x;
  logic [8:0] sprite_write_y;
  logic signed [1:0] sprite_write_dx, sprite_write_dy;
  logic [2:0] lives;
  logic [7:0] score;
  logic       game_over;
  logic [2:0] state_dbg;

  logic       enable_s, upd_s, xy_s, dxy_s;
  logic [9:0] x_s;
  logic [8:0] y_s;
  logic signed [1:0] dx_s, dy_s;
  logic [2:0] lives_s;
  logic [2:0] score_s;
  logic       game_over_s;
  logic [2:0] state_dbg_s;

  int n_checks;
  int n_fail;
  int exp_score;
  logic [3:0] exp_q[$];

  game_round_fsm #(.HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .key_start(key_start), .hit_wall(hit_wall), .collide(collide),
    .enable(enable), .sprite_enable_update(sprite_enable_update),
    .sprite_write_xy(sprite_write_xy), .sprite_write_dxy(sprite_write_dxy),
    .sprite_write_x(sprite_write_x), .sprite_write_y(sprite_write_y),
    .sprite_write_dx(sprite_write_dx), .sprite_write_dy(sprite_write_dy),
    .lives(lives), .score(score), .game_over(game_over), .state_dbg(state_dbg)
  );

  game_round_fsm #(.HOLD_CYCLES(HOLD), .SCORE_WIDTH(3)) dut_s (
    .clk(clk), .rst(rst), .key_start(key_start), .hit_wall(hit_wall), .collide(collide),
    .enable(enable_s), .sprite_enable_update(upd_s),
    .sprite_write_xy(xy_s), .sprite_write_dxy(dxy_s),
    .sprite_write_x(x_s), .sprite_write_y(y_s),
    .sprite_write_dx(dx_s), .sprite_write_dy(dy_s),
    .lives(lives_s), .score(score_s), .game_over(game_over_s), .state_dbg(state_dbg_s)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs and checks happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic catch_pulse();
    collide = 1'b1;
    tick();
    collide = 1'b0;
    tick();
    exp_score++;
  endtask

  // Expects the current cycle to be LOAD_XY; walks LOAD_XY, LOAD_DXY, PLAY
  // comparing {xy, dxy, enable, update} against the scoreboard queue.
  task automatic check_reload(input string tag);
    logic [3:0] exp_v;
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0110);
    exp_q.push_back(4'b0011);
    for (int i = 0; i < 3; i++) begin
      exp_v = exp_q.pop_front();
      check($sformatf("%s_strobes%0d", tag, i),
            {28'd0, sprite_write_xy, sprite_write_dxy, enable, sprite_enable_update},
            {28'd0, exp_v});
      if (i == 0) begin
        check({tag, "_x"}, 32'(sprite_write_x), 32'd316);
        check({tag, "_y"}, 32'(sprite_write_y), 32'd0);
      end
      if (i == 1) begin
        check({tag, "_dx"}, 32'(sprite_write_dx), 32'd1);
        check({tag, "_dy"}, 32'(sprite_write_dy), 32'd1);
      end
      if (i < 2) tick();
    end
  endtask

  // Expects the first HOLD cycle now; checks HOLD_CYCLES frozen cycles.
  task automatic check_hold(input string tag);
    for (int i = 0; i < HOLD; i++) begin
      check($sformatf("%s_state%0d", tag, i), 32'(state_dbg), 32'(ST_HOLD));
      check($sformatf("%s_en%0d", tag, i), 32'(enable), 32'd0);
      tick();
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_score = 0;
    rst       = 1'b1;
    key_start = 1'b0;
    hit_wall  = 1'b0;
    collide   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();

    // Reset / idle
    check("idle_state", 32'(state_dbg), 32'(ST_IDLE));
    check("idle_lives", 32'(lives), 32'd3);
    check("idle_score", 32'(score), 32'd0);
    check("idle_outs", {27'd0, sprite_write_xy, sprite_write_dxy, enable,
                        sprite_enable_update, game_over}, 32'd0);
    check("idle_lives_s", 32'(lives_s), 32'd3);

    // Catches in IDLE are discarded
    collide = 1'b1; tick(); collide = 1'b0; tick();
    check("idle_catch_ignored", 32'(score), 32'd0);

    // Start sequence
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    check_reload("start");
    repeat (3) tick();
    check("play_en", {30'd0, enable, sprite_enable_update}, 32'd3);
    check("play_state", 32'(state_dbg), 32'(ST_PLAY));

    // Catches: 5 pulses plus one long high level counting once
    for (int i = 0; i < 5; i++) catch_pulse();
    check("score5", 32'(score), 32'(exp_score));
    collide = 1'b1;
    repeat (20) tick();
    collide = 1'b0;
    tick();
    exp_score++;
    check("score6", 32'(score), 32'(exp_score));
    check("score6_s", 32'(score_s), 32'd6);
    for (int i = 0; i < 3; i++) catch_pulse();
    check("score9", 32'(score), 32'(exp_score));
    check("score_sat_s", 32'(score_s), 32'd7);

    // First miss; a catch during HOLD is dropped
    hit_wall = 1'b1;
    tick();
    hit_wall = 1'b0;
    check("miss1_lives", 32'(lives), 32'd2);
    for (int i = 0; i < HOLD; i++) begin
      check($sformatf("miss1_state%0d", i), 32'(state_dbg), 32'(ST_HOLD));
      check($sformatf("miss1_en%0d", i), 32'(enable), 32'd0);
      check($sformatf("miss1_upd%0d", i), 32'(sprite_enable_update), 32'd0);
      collide = (i == 1);
      tick();
    end
    collide = 1'b0;
    check("hold_catch_ignored", 32'(score), 32'(exp_score));
    check_reload("reload1");

    // Simultaneous miss and catch: miss wins
    hit_wall = 1'b1;
    collide  = 1'b1;
    tick();
    hit_wall = 1'b0;
    collide  = 1'b0;
    check("simul_lives", 32'(lives), 32'd1);
    check("simul_score", 32'(score), 32'(exp_score));
    check_hold("miss2");
    check_reload("reload2");

    // Third miss leads to OVER with no reload strobes
    tick();
    hit_wall = 1'b1;
    tick();
    hit_wall = 1'b0;
    check("miss3_lives", 32'(lives), 32'd0);
    check_hold("miss3");
    for (int i = 0; i < 3; i++) begin
      check($sformatf("over_state%0d", i), 32'(state_dbg), 32'(ST_OVER));
      check($sformatf("over_outs%0d", i),
            {28'd0, game_over, sprite_write_xy, sprite_write_dxy, enable}, 32'h8);
      check($sformatf("over_lives%0d", i), 32'(lives), 32'd0);
      tick();
    end

    // Restart from OVER
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    exp_score = 0;
    check("restart_lives", 32'(lives), 32'd3);
    check("restart_score", 32'(score), 32'(exp_score));
    check("restart_gover", 32'(game_over), 32'd0);
    check_reload("restart");

    // Reset during HOLD aborts straight to IDLE
    tick();
    hit_wall = 1'b1;
    tick();
    hit_wall = 1'b0;
    tick();
    check("pre_rst_state", 32'(state_dbg), 32'(ST_HOLD));
    check("pre_rst_lives", 32'(lives), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_lives", 32'(lives), 32'd3);
    check("rst_outs", {28'd0, sprite_write_xy, sprite_write_dxy, enable, game_over}, 32'd0);
    tick();
    check("post_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("post_rst_outs", {28'd0, sprite_write_xy, sprite_write_dxy, enable,
                            sprite_enable_update}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
